// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit types, limits and helpers
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
    function automatic logic is_bcd_digit(input bcd_digit_t d);
        return d <= BCD_MAX_DIGIT;
    endfunction
endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc: combinational single-digit BCD increment with carry and validity flag
module bcd_digit_inc
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       cin,
    output bcd_digit_t digit_out,
    output logic       cout,
    output logic       invalid
);
    assign cout      = cin && (digit == BCD_MAX_DIGIT);
    assign digit_out = cout ? '0 : digit + bcd_digit_t'(cin);
    assign invalid   = !is_bcd_digit(digit);
endmodule

// File: rtl/bcd_incrementor.sv
// bcd_incrementor: registered packed-BCD +1 with decimal carry-out and invalid-digit flag
module bcd_incrementor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                          out_valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          carry_out,
    output logic                          err
);
    logic [DIGITS:0]                 carry;
    logic [DIGITS-1:0]               invalid;
    logic [BCD_DIGIT_W*DIGITS-1:0]   inc;
    logic                            bad;
    assign carry[0] = 1'b1;
    assign bad      = |invalid;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_inc u_digit (
            .digit    (in_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .cin      (carry[i]),
            .digit_out(inc[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .cout     (carry[i+1]),
            .invalid  (invalid[i])
        );
    end
    // An invalid operand passes through untouched so no partial increment escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bcd   <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bcd   <= bad ? in_bcd : inc;
                carry_out <= !bad && carry[DIGITS];
                err       <= bad;
            end
        end
    end
endmodule

// File: tb/tb_bcd_incrementor.sv
// tb_bcd_incrementor: directed and randomized checks of bcd_incrementor against a decimal-arithmetic model
module tb_bcd_incrementor;
    localparam int DIGITS = 3;
    localparam int W = 4 * DIGITS;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [W-1:0] in_bcd = '0;
    logic out_valid, carry_out, err;
    logic [W-1:0] out_bcd;
    int n_tests = 0, n_fail = 0;

    bcd_incrementor #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_bcd(out_bcd), .carry_out(carry_out), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model(input logic [W-1:0] x, output logic [W-1:0] y, output logic c, output logic e);
        int v, p;
        v = 0; p = 1; e = 1'b0; c = 1'b0; y = x;
        for (int k = 0; k < DIGITS; k++) begin
            if (x[4*k +: 4] > 4'd9) e = 1'b1;
            v += int'(x[4*k +: 4]) * p;
            p *= 10;
        end
        if (!e) begin
            v = v + 1;
            c = (v == p);
            if (c) v = 0;
            for (int k = 0; k < DIGITS; k++) begin
                y[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] x);
        @(negedge clk);
        in_valid = v;
        in_bcd = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b bcd=%h c=%b e=%b want all 0", out_valid, out_bcd, carry_out, err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_carries();
        logic [W-1:0] ins [9] = '{12'h599, 12'h209, 12'h169, 12'h179, 12'h429, 12'h789, 12'h989, 12'h389, 12'h099};
        logic [W-1:0] exp [9] = '{12'h600, 12'h210, 12'h170, 12'h180, 12'h430, 12'h790, 12'h990, 12'h390, 12'h100};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, ins[i]);
            n_tests++;
            if ({out_valid, out_bcd, carry_out, err} !== {1'b1, exp[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL carry in=%h: got v=%b bcd=%h c=%b e=%b want v=1 bcd=%h c=0 e=0",
                         ins[i], out_valid, out_bcd, carry_out, err, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 12'h999);
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== {1'b1, 12'h000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap: got v=%b bcd=%h c=%b e=%b want v=1 bcd=000 c=1 e=0", out_valid, out_bcd, carry_out, err);
        end
    endtask

    task automatic test_invalid();
        step(1'b1, 12'h1A3);
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== {1'b1, 12'h1A3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL invalid: got v=%b bcd=%h c=%b e=%b want v=1 bcd=1a3 c=0 e=1", out_valid, out_bcd, carry_out, err);
        end
        step(1'b1, 12'h123);
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== {1'b1, 12'h124, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL after_invalid: got v=%b bcd=%h c=%b e=%b want v=1 bcd=124 c=0 e=0", out_valid, out_bcd, carry_out, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ins [4] = '{12'h359, 12'h769, 12'h629, 12'h439};
        logic [W-1:0] exp [4] = '{12'h360, 12'h770, 12'h630, 12'h440};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ins[i]);
            n_tests++;
            if ({out_valid, out_bcd, carry_out, err} !== {1'b1, exp[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stream in=%h: got v=%b bcd=%h want v=1 bcd=%h", ins[i], out_valid, out_bcd, exp[i]);
            end
        end
        step(1'b0, 12'h555);
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== {1'b0, 12'h440, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold: got v=%b bcd=%h c=%b e=%b want v=0 bcd=440 c=0 e=0", out_valid, out_bcd, carry_out, err);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        in_bcd = 12'h555;
        #1;
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b bcd=%h c=%b e=%b want all 0", out_valid, out_bcd, carry_out, err);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_discard: got v=%b bcd=%h c=%b e=%b want all 0", out_valid, out_bcd, carry_out, err);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 12'h000);
        n_tests++;
        if ({out_valid, out_bcd, carry_out, err} !== {1'b1, 12'h001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset: got v=%b bcd=%h c=%b e=%b want v=1 bcd=001 c=0 e=0", out_valid, out_bcd, carry_out, err);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] hb = 12'h001, x, y;
        logic hc = 1'b0, he = 1'b0, c, e, v;
        for (int i = 0; i < 400; i++) begin
            x = W'($urandom);
            if ($urandom_range(0, 3) != 0)
                for (int k = 0; k < DIGITS; k++) x[4*k +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) x = 12'h999;
            v = ($urandom_range(0, 4) != 0);
            step(v, x);
            if (v) begin
                model(x, y, c, e);
                hb = y; hc = c; he = e;
            end
            n_tests++;
            if ({out_valid, out_bcd, carry_out, err} !== {v, hb, hc, he}) begin
                n_fail++;
                $display("FAIL random in=%h iv=%b: got v=%b bcd=%h c=%b e=%b want v=%b bcd=%h c=%b e=%b",
                         x, v, out_valid, out_bcd, carry_out, err, v, hb, hc, he);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carries();
        test_wrap();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
